// File: rtl/control_acceso_if.sv
// Gate-side bundle for control_acceso: requests, lane sensor and counter feedback in,
// barrier/counter pulses and status out.
interface control_acceso_if #(
  parameter int unsigned CW = 3
) ();
  logic          req_in;
  logic          req_out;
  logic          paso;
  logic [CW-1:0] count;
  logic          x;
  logic          y;
  logic          barrera;
  logic          dir;
  logic          busy;
  logic          lleno;
  logic          expira;

  modport master (
    output req_in, req_out, paso, count,
    input  x, y, barrera, dir, busy, lleno, expira
  );

  modport slave (
    input  req_in, req_out, paso, count,
    output x, y, barrera, dir, busy, lleno, expira
  );
endinterface

// File: rtl/control_acceso.sv
// Single-lane bidirectional gate controller: arbitrates entry/exit requests, opens the
// shared barrier and issues one x (entry) or y (exit) pulse per completed passage.
module control_acceso #(
  parameter int unsigned CW       = 3,
  parameter int unsigned CAPACITY = 7,
  parameter int unsigned T_OPEN   = 50,
  parameter int unsigned TW       = 6
) (
  input  logic            clk,
  input  logic            reset,
  control_acceso_if.slave bus
);

  localparam logic [TW-1:0] TIMER_LAST = TW'(T_OPEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    ESPERA_LLEGADA,
    ESPERA_SALIDA,
    PULSO
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic          last_dir, last_dir_n;
  logic          dir_q, dir_n;
  logic          barrera_q, barrera_n;
  logic          x_q, x_n;
  logic          y_q, y_n;
  logic          expira_q, expira_n;

  logic          lleno_c;
  logic          ent_ok;
  logic          sal_ok;
  logic          gnt_dir;

  // Request qualification: no entry when full, no exit when empty
  assign lleno_c = (bus.count == CW'(CAPACITY));
  assign ent_ok  = bus.req_in & ~lleno_c;
  assign sal_ok  = bus.req_out & (bus.count != '0);
  // Single requester wins outright; on a tie the direction not served last goes
  assign gnt_dir = (ent_ok & sal_ok) ? ~last_dir : sal_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      timer     <= '0;
      last_dir  <= 1'b0;
      dir_q     <= 1'b0;
      barrera_q <= 1'b0;
      x_q       <= 1'b0;
      y_q       <= 1'b0;
      expira_q  <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      last_dir  <= last_dir_n;
      dir_q     <= dir_n;
      barrera_q <= barrera_n;
      x_q       <= x_n;
      y_q       <= y_n;
      expira_q  <= expira_n;
    end
  end

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    last_dir_n = last_dir;
    dir_n      = dir_q;
    barrera_n  = barrera_q;
    x_n        = 1'b0;
    y_n        = 1'b0;
    expira_n   = 1'b0;

    unique case (state)
      IDLE: begin
        // A car still in the lane blocks any new grant
        if (!bus.paso && (ent_ok || sal_ok)) begin
          state_n   = ESPERA_LLEGADA;
          dir_n     = gnt_dir;
          barrera_n = 1'b1;
          timer_n   = '0;
        end
      end
      ESPERA_LLEGADA: begin
        if (bus.paso) begin
          state_n = ESPERA_SALIDA;
        end else if (timer == TIMER_LAST) begin
          state_n   = IDLE;
          barrera_n = 1'b0;
          expira_n  = 1'b1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      ESPERA_SALIDA: begin
        if (!bus.paso) begin
          state_n   = PULSO;
          barrera_n = 1'b0;
          x_n       = ~dir_q;
          y_n       = dir_q;
        end
      end
      PULSO: begin
        state_n    = IDLE;
        last_dir_n = dir_q;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.barrera = barrera_q;
  assign bus.dir     = dir_q;
  assign bus.expira  = expira_q;
  assign bus.busy    = (state != IDLE);
  assign bus.lleno   = lleno_c;

endmodule

// File: tb/tb_control_acceso.sv
// Randomized and directed bench for control_acceso against a passage-level reference
// model that also plays the occupancy counter.
module tb_control_acceso;

  localparam int unsigned CW    = 3;
  localparam int unsigned CAP   = 7;
  localparam int unsigned TOPEN = 50;
  localparam int unsigned TW    = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_acceso_if #(.CW(CW)) bus ();

  control_acceso #(
    .CW      (CW),
    .CAPACITY(CAP),
    .T_OPEN  (TOPEN),
    .TW      (TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference: one open grant at a time, described by what has happened to the car so far
  int occ;
  bit g_open;
  bit car_seen;
  bit pulse_now;
  bit g_dir;
  bit served_last;
  bit e_bar;
  bit e_x;
  bit e_y;
  bit e_exp;
  int waited;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    g_open      = 1'b0;
    car_seen    = 1'b0;
    pulse_now   = 1'b0;
    g_dir       = 1'b0;
    served_last = 1'b0;
    e_bar       = 1'b0;
    e_x         = 1'b0;
    e_y         = 1'b0;
    e_exp       = 1'b0;
    waited      = 0;
  endtask

  task automatic model_edge(input bit ri, input bit ro, input bit p);
    bit want_in;
    bit want_out;
    e_x   = 1'b0;
    e_y   = 1'b0;
    e_exp = 1'b0;
    if (pulse_now) begin
      occ         = g_dir ? occ - 1 : occ + 1;
      served_last = g_dir;
      pulse_now   = 1'b0;
    end else if (!g_open) begin
      want_in  = ri && (occ != int'(CAP));
      want_out = ro && (occ != 0);
      if (!p && (want_in || want_out)) begin
        g_dir    = (want_in && want_out) ? !served_last : want_out;
        g_open   = 1'b1;
        car_seen = 1'b0;
        waited   = 0;
        e_bar    = 1'b1;
      end
    end else if (!car_seen) begin
      if (p) car_seen = 1'b1;
      else if (waited == int'(TOPEN) - 1) begin
        g_open = 1'b0;
        e_bar  = 1'b0;
        e_exp  = 1'b1;
      end else waited++;
    end else if (!p) begin
      g_open    = 1'b0;
      e_bar     = 1'b0;
      pulse_now = 1'b1;
      e_x       = !g_dir;
      e_y       = g_dir;
    end
  endtask

  task automatic compare();
    check("x",       bus.x,       e_x);
    check("y",       bus.y,       e_y);
    check("barrera", bus.barrera, e_bar);
    check("dir",     bus.dir,     g_dir);
    check("expira",  bus.expira,  e_exp);
    check("busy",    bus.busy,    g_open || pulse_now);
    check("lleno",   bus.lleno,   occ == int'(CAP));
  endtask

  task automatic step(input bit ri, input bit ro, input bit p);
    bus.req_in  = ri;
    bus.req_out = ro;
    bus.paso    = p;
    @(posedge clk);
    model_edge(ri, ro, p);
    #1 bus.count = CW'(occ);
    #1 compare();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_barrera"}, bus.barrera, 0);
    check({tag, "_x"},       bus.x,       0);
    check({tag, "_y"},       bus.y,       0);
    check({tag, "_expira"},  bus.expira,  0);
    check({tag, "_busy"},    bus.busy,    0);
    check({tag, "_dir"},     bus.dir,     0);
  endtask

  // Asynchronous reset asserted mid-cycle, held across two rising edges
  task automatic do_reset();
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("rst_hold");
    #2 reset = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 70; i++) begin
      if (!g_open && !pulse_now) break;
      step(1'b0, 1'b0, 1'b0);
    end
    check("drain_idle", bus.busy, 0);
  endtask

  task automatic set_occ(input int v);
    occ       = v;
    bus.count = CW'(v);
    #1;
  endtask

  task automatic passage(input bit ri, input bit ro, input int pre, input int in_lane);
    for (int i = 0; i < pre; i++) step(ri, ro, 1'b0);
    for (int i = 0; i < in_lane; i++) step(ri, ro, 1'b1);
    step(ri, ro, 1'b0);
  endtask

  bit r_in, r_out, r_paso;

  initial begin
    reset       = 1'b0;
    bus.req_in  = 1'b0;
    bus.req_out = 1'b0;
    bus.paso    = 1'b0;
    bus.count   = '0;
    occ         = 0;
    model_reset();
    #12 check_reset_outputs("por");
    #11 reset = 1'b1;

    // Basic entry with a car passing
    step(1'b1, 1'b0, 1'b0);
    check("grant_entry_bar", bus.barrera, 1);
    check("grant_entry_dir", bus.dir, 0);
    passage(1'b0, 1'b0, 2, 4);
    check("entry_x_pulse", bus.x, 1);
    check("entry_bar_low", bus.barrera, 0);
    step(1'b0, 1'b0, 1'b0);
    drain();

    // Full lot refuses entry; one exit then frees a space
    set_occ(7);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
    check("full_no_grant", bus.barrera, 0);
    passage(1'b0, 1'b1, 3, 2);
    check("exit_y_pulse", bus.y, 1);
    step(1'b0, 1'b0, 1'b0);
    check("lleno_drop", bus.lleno, 0);
    drain();

    // Tie after reset: exit first, then alternating
    do_reset();
    set_occ(3);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0);
      check("tie_dir", bus.dir, ((k % 2) == 0) ? 1 : 0);
      passage(1'b1, 1'b1, 1, 2);
      step(1'b1, 1'b1, 1'b0);
    end
    drain();

    // Arrival timeout with request still held, then immediate re-grant
    set_occ(3);
    for (int i = 0; i < 2 * int'(TOPEN) + 5; i++) step(1'b1, 1'b0, 1'b0);
    drain();

    // Empty lot blocks exit; occupied lane blocks entry
    set_occ(0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
    check("empty_no_grant", bus.busy, 0);
    set_occ(4);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
    check("lane_blocked", bus.busy, 0);
    passage(1'b1, 1'b0, 2, 3);
    drain();

    // Reset while the car is in the lane: no pulse afterwards
    set_occ(2);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

    // Randomized traffic
    r_in   = 1'b0;
    r_out  = 1'b0;
    r_paso = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) r_in = ~r_in;
      if ($urandom_range(0, 9) == 0) r_out = ~r_out;
      if ($urandom_range(0, 5) == 0) r_paso = ~r_paso;
      step(r_in, r_out, r_paso);
      if ($urandom_range(0, 399) == 0) do_reset();
      if ((c % 800) == 799) begin
        drain();
        set_occ(int'($urandom_range(0, CAP)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
